control_sequencer: RTL and testbench
====================================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: ports clk and reset.
REQ-002 Ports, in order: clk in 1 (rising-edge clock); reset in 1 (sync clear); run in 1 (start/continue execution); IR in 32 (instruction register contents); mem_ready in 1 (memory transfer complete).
REQ-003 Ports, continued: Rin out 16 (one-hot GPR write enables); Rout out 16 (one-hot GPR bus drivers); PCout, PCin, IRin, MARin, MDRin, MDRout, Read, Write, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, IncPC out 1 each; alu_op out 5; illegal_op out 1 (one-cycle pulse); halted out 1.
REQ-004 Instruction fields SHALL be: op = IR[31:27]; Ra = IR[26:23]; Rb = IR[22:19]; Rc = IR[18:15].

Function
REQ-005 Control outputs SHALL be Moore outputs, decoded from the registered state and IR fields only.
REQ-006 At most one bus driver SHALL be active per cycle: one bit of Rout, or one of PCout, MDRout, Zlowout, Zhighout, Cout.
REQ-007 States SHALL be: IDLE, F0-F3, E0-E4, HALTED.
REQ-008 IDLE: all outputs 0; SHALL go to F0 when run=1.
REQ-009 F0: PCout, MARin, IncPC, Zin. F1: Zlowout, PCin.
REQ-010 F2: Read and MDRin SHALL hold until mem_ready=1 is sampled; the state then goes to F3 on that edge. There is no timeout.
REQ-011 F3: MDRout, IRin. The state then goes to E0.
REQ-012 ALU ops (add 02, sub 03, and 04, or 05): E0 Rout[Rb], Yin; E1 Rout[Rc], Zin, alu_op=op; E2 Zlowout, Rin[Ra]. Execution takes 3 cycles.
REQ-013 ld (00): E0 Rout[Rb], Yin; E1 Cout, Zin, alu_op=02; E2 Zlowout, MARin; E3 Read, MDRin, held until mem_ready; E4 MDRout, Rin[Ra].
REQ-014 st (01): E0-E2 as for ld; E3 Rout[Ra], MDRin (Read=0); E4 Write, held until mem_ready.
REQ-015 mul (0F), div (10): E0 Rout[Ra], Yin; E1 Rout[Rb], Zin, alu_op=op; E2 Zlowout, LOin; E3 Zhighout, HIin.
REQ-016 nop (18): E0 with no outputs asserted.
REQ-017 halt (19): the state SHALL go to HALTED from E0. HALTED asserts halted=1 and all other outputs 0, and is left only by reset.
REQ-018 An unlisted op SHALL pulse illegal_op for one cycle in E0 and then go to the next instruction.
REQ-019 alu_op SHALL be 0 in every state not listed above.
REQ-020 At the end of every instruction, the state SHALL go to F0 if run=1, else to IDLE. Deasserting run mid-instruction SHALL NOT abort the instruction.
REQ-021 mem_ready SHALL be ignored outside F2 and the ld-E3 / st-E4 wait states.

Reset
REQ-022 reset=1 at a rising edge SHALL force IDLE from any state, including the F2/E3/E4 memory waits and HALTED.
REQ-023 reset SHALL take priority over run and mem_ready.
REQ-024 In the cycle after reset, all outputs SHALL be 0, including Rin, Rout, alu_op, illegal_op and halted.

Configuration
REQ-025 Macro MULDIV_EN defined: mul and div SHALL be sequenced per REQ-015.
REQ-026 Macro MULDIV_EN undefined: opcodes 0F and 10 SHALL be treated as illegal per REQ-018, and HIin, LOin and Zhighout SHALL be tied to 0.

Verification
REQ-027 Reset, run=1, mem_ready tied 1, IR=add R3,R1,R2 (op 02, Ra 3, Rb 1, Rc 2) -> F0-F3 then E0 Rout=0x0002 with Yin; E1 Rout=0x0004 with Zin and alu_op=02; E2 Rin=0x0008 with Zlowout; 7 cycles total.
REQ-028 Fetch with mem_ready held low for 5 cycles -> Read=MDRin=1 for exactly 6 cycles; IRin asserts one cycle after mem_ready rises.
REQ-029 IR=ld R4 (Ra 4, Rb 0) with mem_ready=1 -> E2 MARin; E4 Rin=0x0010 with MDRout. IR=st R4 -> E3 Rout=0x0010 with MDRin; E4 Write=1.
REQ-030 IR op=1F -> illegal_op high for exactly one cycle; the next cycle is F0; no Rin bit is asserted.
REQ-031 IR=halt -> halted=1 indefinitely while run toggles; reset asserted during the F2 wait -> all outputs 0 the next cycle and the state is IDLE.
REQ-032 IR=mul (op 0F) -> with MULDIV_EN: LOin then HIin in consecutive cycles; without MULDIV_EN: illegal_op pulse.

Source files
------------

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - Hardwired fetch/execute control sequencer; define MULDIV_EN to sequence mul/div
module control_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic        Cout,
  output logic        IncPC,
  output logic [4:0]  alu_op,
  output logic        illegal_op,
  output logic        halted
);

  typedef enum logic [3:0] {
    IDLE, F0, F1, F2, F3, E0, E1, E2, E3, E4, HALTED
  } state_t;

  localparam logic [4:0] OP_LD   = 5'h00;
  localparam logic [4:0] OP_ST   = 5'h01;
  localparam logic [4:0] OP_ADD  = 5'h02;
  localparam logic [4:0] OP_SUB  = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04;
  localparam logic [4:0] OP_OR   = 5'h05;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NOP  = 5'h18;
  localparam logic [4:0] OP_HALT = 5'h19;

  state_t state;
  state_t state_n;

  logic [4:0] op;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic [14:0] unused_ir;

  logic is_alu;
  logic is_ld;
  logic is_st;
  logic is_mem;
  logic is_muldiv;
  logic is_nop;
  logic is_halt;
  logic is_legal;
  state_t done_state;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = IR[14:0];

  assign is_alu  = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  assign is_ld   = (op == OP_LD);
  assign is_st   = (op == OP_ST);
  assign is_mem  = is_ld || is_st;
  assign is_nop  = (op == OP_NOP);
  assign is_halt = (op == OP_HALT);
`ifdef MULDIV_EN
  assign is_muldiv = (op == OP_MUL) || (op == OP_DIV);
`else
  assign is_muldiv = 1'b0;
`endif
  assign is_legal = is_alu || is_mem || is_muldiv || is_nop || is_halt;

  // Every instruction ends by chaining to the next fetch only while run is held.
  assign done_state = run ? F0 : IDLE;

  // One-hot register select from a 4-bit register field.
  function automatic logic [15:0] reg_sel(input logic [3:0] idx);
    reg_sel = 16'h0001 << idx;
  endfunction

  // Next-state selection; memory waits only look at mem_ready in F2, ld-E3 and st-E4.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (run) state_n = F0;
      F0:     state_n = F1;
      F1:     state_n = F2;
      F2:     if (mem_ready) state_n = F3;
      F3:     state_n = E0;
      E0: begin
        if (is_halt)                          state_n = HALTED;
        else if (is_alu || is_mem || is_muldiv) state_n = E1;
        else                                  state_n = done_state;
      end
      E1:     state_n = E2;
      E2: begin
        if (is_alu) state_n = done_state;
        else        state_n = E3;
      end
      E3: begin
        if (is_ld) begin
          if (mem_ready) state_n = E4;
        end else if (is_st) begin
          state_n = E4;
        end else begin
          state_n = done_state;
        end
      end
      E4: begin
        if (is_st) begin
          if (mem_ready) state_n = done_state;
        end else begin
          state_n = done_state;
        end
      end
      HALTED: state_n = HALTED;
      default: state_n = IDLE;
    endcase
  end

  // State register; reset wins over run and mem_ready from every state, HALTED included.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Moore output decode from the registered state and the current IR fields.
  always_comb begin
    Rin        = 16'h0000;
    Rout       = 16'h0000;
    PCout      = 1'b0;
    PCin       = 1'b0;
    IRin       = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    Read       = 1'b0;
    Write      = 1'b0;
    Yin        = 1'b0;
    Zin        = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Cout       = 1'b0;
    IncPC      = 1'b0;
    alu_op     = 5'h00;
    illegal_op = 1'b0;
    halted     = 1'b0;
    case (state)
      F0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      F1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
      end
      F2: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      F3: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      E0: begin
        if (is_alu || is_mem) begin
          Rout = reg_sel(rb);
          Yin  = 1'b1;
        end else if (is_muldiv) begin
          Rout = reg_sel(ra);
          Yin  = 1'b1;
        end else if (!is_legal) begin
          illegal_op = 1'b1;
        end
      end
      E1: begin
        if (is_alu) begin
          Rout   = reg_sel(rc);
          Zin    = 1'b1;
          alu_op = op;
        end else if (is_mem) begin
          // Effective address is Rb plus the constant on the C bus.
          Cout   = 1'b1;
          Zin    = 1'b1;
          alu_op = OP_ADD;
        end else if (is_muldiv) begin
          Rout   = reg_sel(rb);
          Zin    = 1'b1;
          alu_op = op;
        end
      end
      E2: begin
        if (is_alu) begin
          Zlowout = 1'b1;
          Rin     = reg_sel(ra);
        end else if (is_mem) begin
          Zlowout = 1'b1;
          MARin   = 1'b1;
        end
`ifdef MULDIV_EN
        else if (is_muldiv) begin
          Zlowout = 1'b1;
          LOin    = 1'b1;
        end
`endif
      end
      E3: begin
        if (is_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end else if (is_st) begin
          Rout  = reg_sel(ra);
          MDRin = 1'b1;
        end
`ifdef MULDIV_EN
        else if (is_muldiv) begin
          Zhighout = 1'b1;
          HIin     = 1'b1;
        end
`endif
      end
      E4: begin
        if (is_ld) begin
          MDRout = 1'b1;
          Rin    = reg_sel(ra);
        end else if (is_st) begin
          Write = 1'b1;
        end
      end
      HALTED: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - Directed self-checking bench for control_sequencer
module tb_control_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [31:0] IR;
  logic        mem_ready;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        PCout, PCin, IRin, MARin, MDRin, MDRout, Read, Write;
  logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin, Cout, IncPC;
  logic [4:0]  alu_op;
  logic        illegal_op;
  logic        halted;

  int n_cmp;
  int n_err;

  localparam logic [15:0] C_PCOUT   = 16'h8000;
  localparam logic [15:0] C_PCIN    = 16'h4000;
  localparam logic [15:0] C_IRIN    = 16'h2000;
  localparam logic [15:0] C_MARIN   = 16'h1000;
  localparam logic [15:0] C_MDRIN   = 16'h0800;
  localparam logic [15:0] C_MDROUT  = 16'h0400;
  localparam logic [15:0] C_READ    = 16'h0200;
  localparam logic [15:0] C_WRITE   = 16'h0100;
  localparam logic [15:0] C_YIN     = 16'h0080;
  localparam logic [15:0] C_ZIN     = 16'h0040;
  localparam logic [15:0] C_ZLOW    = 16'h0020;
  localparam logic [15:0] C_ZHIGH   = 16'h0010;
  localparam logic [15:0] C_HIIN    = 16'h0008;
  localparam logic [15:0] C_LOIN    = 16'h0004;
  localparam logic [15:0] C_COUT    = 16'h0002;
  localparam logic [15:0] C_INCPC   = 16'h0001;

  localparam logic [31:0] IR_ADD  = 32'h1189_0000;  // add R3,R1,R2
  localparam logic [31:0] IR_NOP  = 32'hC000_0000;
  localparam logic [31:0] IR_LD   = 32'h0200_0000;  // ld R4, Rb=0
  localparam logic [31:0] IR_ST   = 32'h0A00_0000;  // st R4, Rb=0
  localparam logic [31:0] IR_ILL  = 32'hF800_0000;  // op 1F
  localparam logic [31:0] IR_OR   = 32'h2F83_8000;  // or R15,R0,R7
  localparam logic [31:0] IR_MUL  = 32'h7928_0000;  // mul Ra=2, Rb=5
  localparam logic [31:0] IR_HALT = 32'hC800_0000;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .IR(IR), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin),
    .MDRout(MDRout), .Read(Read), .Write(Write), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Cout(Cout), .IncPC(IncPC), .alu_op(alu_op), .illegal_op(illegal_op),
    .halted(halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [15:0] ctl, input logic [15:0] rin,
                     input logic [15:0] rout, input logic [4:0] alu, input logic ill,
                     input logic hlt);
    logic [54:0] obs;
    logic [54:0] exp;
    obs = {PCout, PCin, IRin, MARin, MDRin, MDRout, Read, Write, Yin, Zin, Zlowout,
           Zhighout, HIin, LOin, Cout, IncPC, Rin, Rout, alu_op, illegal_op, halted};
    exp = {ctl, rin, rout, alu, ill, hlt};
    n_cmp++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%h expected=%h (ctl|Rin|Rout|alu|ill|halt)", tag, obs, exp);
      end
  endtask

  // Checks F0..F3 starting in F0 with mem_ready high; returns in E0.
  task automatic fetch(input string tag);
    chk({tag, "_f0"}, C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk({tag, "_f1"}, C_ZLOW | C_PCIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk({tag, "_f2"}, C_READ | C_MDRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk({tag, "_f3"}, C_MDROUT | C_IRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    run = 1'b0;
    IR = 32'h0;
    mem_ready = 1'b0;
    tick();
    chk("reset", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);

    // add R3,R1,R2; run dropped mid-instruction must not abort it
    reset = 1'b0;
    run = 1'b1;
    mem_ready = 1'b1;
    IR = IR_ADD;
    tick();
    fetch("add");
    chk("add_e0", C_YIN, 16'h0, 16'h0002, 5'h00, 1'b0, 1'b0);
    run = 1'b0;
    tick();
    chk("add_e1", C_ZIN, 16'h0, 16'h0004, 5'h02, 1'b0, 1'b0);
    tick();
    chk("add_e2", C_ZLOW, 16'h0008, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("add_idle", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);

    // fetch with mem_ready low for 5 cycles
    IR = IR_NOP;
    run = 1'b1;
    mem_ready = 1'b0;
    tick();
    chk("wait_f0", C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("wait_f1", C_ZLOW | C_PCIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("wait_f2_low", C_READ | C_MDRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
      tick();
    end
    chk("wait_f2_6th", C_READ | C_MDRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick();
    chk("wait_f3", C_MDROUT | C_IRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("nop_e0", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();

    // ld R4 with a one-cycle data wait in E3
    IR = IR_LD;
    fetch("ld");
    chk("ld_e0", C_YIN, 16'h0, 16'h0001, 5'h00, 1'b0, 1'b0);
    tick();
    chk("ld_e1", C_COUT | C_ZIN, 16'h0, 16'h0, 5'h02, 1'b0, 1'b0);
    tick();
    chk("ld_e2", C_ZLOW | C_MARIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("ld_e3", C_READ | C_MDRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    mem_ready = 1'b0;
    tick();
    chk("ld_e3_wait", C_READ | C_MDRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick();
    chk("ld_e4", C_MDROUT, 16'h0010, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();

    // st R4; mem_ready low in E3 is ignored, then holds Write in E4
    IR = IR_ST;
    fetch("st");
    chk("st_e0", C_YIN, 16'h0, 16'h0001, 5'h00, 1'b0, 1'b0);
    tick();
    chk("st_e1", C_COUT | C_ZIN, 16'h0, 16'h0, 5'h02, 1'b0, 1'b0);
    tick();
    chk("st_e2", C_ZLOW | C_MARIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("st_e3", C_MDRIN, 16'h0, 16'h0010, 5'h00, 1'b0, 1'b0);
    mem_ready = 1'b0;
    tick();
    chk("st_e4", C_WRITE, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("st_e4_wait", C_WRITE, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    mem_ready = 1'b1;
    tick();

    // illegal opcode 1F
    IR = IR_ILL;
    fetch("ill");
    chk("ill_e0", 16'h0, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
    tick();

    // or R15,R0,R7 exercises the top register index
    IR = IR_OR;
    fetch("or");
    chk("or_e0", C_YIN, 16'h0, 16'h0001, 5'h00, 1'b0, 1'b0);
    tick();
    chk("or_e1", C_ZIN, 16'h0, 16'h0080, 5'h05, 1'b0, 1'b0);
    tick();
    chk("or_e2", C_ZLOW, 16'h8000, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();

    // mul Ra=2, Rb=5
    IR = IR_MUL;
    fetch("mul");
`ifdef MULDIV_EN
    chk("mul_e0", C_YIN, 16'h0, 16'h0004, 5'h00, 1'b0, 1'b0);
    tick();
    chk("mul_e1", C_ZIN, 16'h0, 16'h0020, 5'h0F, 1'b0, 1'b0);
    tick();
    chk("mul_e2", C_ZLOW | C_LOIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("mul_e3", C_ZHIGH | C_HIIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
`else
    chk("mul_ill", 16'h0, 16'h0, 16'h0, 5'h00, 1'b1, 1'b0);
    tick();
`endif

    // halt, then run and mem_ready toggling must not leave HALTED
    IR = IR_HALT;
    fetch("halt");
    chk("halt_e0", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    chk("halted", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      mem_ready = ~i[0];
      tick();
      chk("halted_hold", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b1);
    end
    reset = 1'b1;
    tick();
    chk("rst_halted", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);

    // reset during the F2 wait, asserted alongside run and mem_ready
    reset = 1'b0;
    run = 1'b1;
    mem_ready = 1'b0;
    IR = IR_NOP;
    tick();
    tick();
    tick();
    chk("rst_f2_pre", C_READ | C_MDRIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    tick();
    chk("rst_f2", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    reset = 1'b0;
    run = 1'b0;
    tick();
    chk("rst_idle", 16'h0, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);
    run = 1'b1;
    tick();
    chk("rst_restart", C_PCOUT | C_MARIN | C_INCPC | C_ZIN, 16'h0, 16'h0, 5'h00, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
